// File: rtl/regs_dump_if.sv
// Output stream of the register dump: one (address, data) beat per transfer.
// A beat transfers on a rising edge where out_valid and out_ready are both high; the
// source holds out_addr/out_data stable while out_valid is high and out_ready is low.
interface regs_dump_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [WIDTH-1:0]      out_data;

  modport master (output out_valid, output out_addr, output out_data, input out_ready);
  modport slave  (input out_valid, input out_addr, input out_data, output out_ready);
endinterface

// File: rtl/regs_dump.sv
// Debug reader that freezes the register file, walks every address once and
// streams (address, data) beats with back-pressure while XOR-accumulating a checksum.
module regs_dump #(
  parameter int WIDTH      = 32,
  parameter int NR_REGS    = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  hold,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      din,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      checksum,
  output logic [1:0]            dbg_state,
  regs_dump_if.master           dump
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  out_valid_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [WIDTH-1:0]      out_data_q;
  logic [WIDTH-1:0]      sum_q;
  logic                  load;
  logic                  last;
  logic                  beat_done;

  // The output register refills whenever it is empty or its beat leaves this cycle.
  assign load      = (state == READ) && (!out_valid_q || dump.out_ready);
  assign last      = (idx == ADDR_WIDTH'(NR_REGS - 1));
  assign beat_done = out_valid_q && dump.out_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = READ;
      READ:    if (load && last) state_next = DRAIN;
      DRAIN:   if (beat_done) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      sum_q       <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        idx   <= '0;
        sum_q <= '0;
      end
      if (load) begin
        out_valid_q <= 1'b1;
        out_addr_q  <= idx;
        out_data_q  <= din;
        sum_q       <= sum_q ^ din;
        // Compare before incrementing so a full 2^ADDR_WIDTH file never wraps idx.
        if (!last) idx <= idx + ADDR_WIDTH'(1);
      end else if (beat_done) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign hold           = (state == READ);
  assign addr           = hold ? idx : '0;
  assign busy           = (state != IDLE);
  assign done           = (state == FIN);
  assign checksum       = sum_q;
  assign dbg_state      = state;
  assign dump.out_valid = out_valid_q;
  assign dump.out_addr  = out_addr_q;
  assign dump.out_data  = out_data_q;

endmodule

// File: tb/tb_regs_dump.sv
// Bench for regs_dump: scenario table over a 32-register file plus hand-written
// reset-abort and 4-register sequences, checked against a queue-based reference.
module tb_regs_dump;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (32 registers) ----------------
  logic          start = 1'b0;
  logic          hold;
  logic [AW-1:0] addr;
  logic [W-1:0]  din;
  logic          busy;
  logic          done;
  logic [W-1:0]  checksum;
  logic [1:0]    dbg_state;
  logic [W-1:0]  regs [NR];

  regs_dump_if #(.WIDTH(W), .ADDR_WIDTH(AW)) dif ();
  assign din = regs[addr];

  regs_dump #(.WIDTH(W), .NR_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .addr(addr), .din(din),
    .busy(busy), .done(done), .checksum(checksum), .dbg_state(dbg_state), .dump(dif)
  );

  // ---------------- small DUT (4 registers, full address space) ----------------
  logic         s_start = 1'b0;
  logic         s_hold;
  logic [1:0]   s_addr;
  logic [W-1:0] s_din;
  logic         s_busy;
  logic         s_done;
  logic [W-1:0] s_checksum;
  logic [1:0]   s_dbg_state;
  logic [W-1:0] s_regs [4];

  regs_dump_if #(.WIDTH(W), .ADDR_WIDTH(2)) sif ();
  assign s_din = s_regs[s_addr];

  regs_dump #(.WIDTH(W), .NR_REGS(4), .ADDR_WIDTH(2)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .hold(s_hold), .addr(s_addr), .din(s_din),
    .busy(s_busy), .done(s_done), .checksum(s_checksum), .dbg_state(s_dbg_state), .dump(sif)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [AW+W-1:0] exp_q[$];
  logic [W-1:0]    exp_sum;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mode: 0 ready always, 1 alternating from 0, 2 random, 3 stalled 10 cycles on beat 0
  typedef struct {
    int          mode;
    bit          preset;
    bit          restart;
    logic [W-1:0] exp_sum;
  } vec_t;

  vec_t vecs[6];

  // ---------------- driver tasks ----------------
  task automatic load_regs(input bit preset);
    for (int i = 0; i < NR; i++) begin
      if (i == 0)      regs[i] = '0;
      else if (preset) regs[i] = 32'h100 + W'(i);
      else             regs[i] = $urandom;
    end
  endtask

  // Reference: every register in address order, checksum is XOR of all values.
  task automatic build_expect();
    exp_q.delete();
    exp_sum = '0;
    for (int i = 0; i < NR; i++) begin
      exp_q.push_back({AW'(i), regs[i]});
      exp_sum ^= regs[i];
    end
  endtask

  task automatic run_dump(input vec_t v);
    int   k;
    bit   seen;
    bit   r;
    bit   stalled;
    logic [AW-1:0] paddr;
    logic [W-1:0]  pdata;
    logic [W-1:0]  want_sum;
    logic [AW+W-1:0] e;

    load_regs(v.preset);
    build_expect();
    want_sum = v.preset ? v.exp_sum : exp_sum;
    seen = 0; stalled = 0; paddr = '0; pdata = '0;
    dif.out_ready = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 1;
    check("busy_after_start", busy, 1);
    check("hold_after_start", hold, 1);
    while (!seen && k < 600) begin
      case (v.mode)
        0:       r = 1'b1;
        1:       r = (k % 2 == 1);
        2:       r = ($urandom_range(0, 3) != 0);
        default: r = !(k >= 2 && k < 12);
      endcase
      dif.out_ready = r;
      if (stalled) begin
        check("stall_valid", dif.out_valid, 1);
        check("stall_addr", dif.out_addr, paddr);
        check("stall_data", dif.out_data, pdata);
      end
      if (v.mode == 3 && k >= 2 && k < 12) begin
        check("stall_rf_addr", addr, 1);
        check("stall_hold", hold, 1);
      end
      if (v.mode == 0 && k == NR + 1) begin
        check("drain_hold", hold, 0);
        check("drain_busy", busy, 1);
      end
      if (dif.out_valid && r) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_beat: got addr %0h data %0h expected no beat", dif.out_addr, dif.out_data);
        end else begin
          e = exp_q.pop_front();
          check("beat", {dif.out_addr, dif.out_data}, e);
        end
      end
      stalled = dif.out_valid && !r;
      paddr   = dif.out_addr;
      pdata   = dif.out_data;
      if (done) begin
        check("beats_left", exp_q.size(), 0);
        check("checksum", checksum, want_sum);
        if (v.mode == 0) check("done_cycle", k, NR + 2);
        seen = 1;
      end
      start = v.restart && ((dif.out_valid && dif.out_addr == 5) || done);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (!seen) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done in %0d cycles expected done", k);
    end
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("idle_hold", hold, 0);
    check("checksum_held", checksum, want_sum);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{mode: 0, preset: 1'b1, restart: 1'b0, exp_sum: 32'h100};
    vecs[1] = '{mode: 1, preset: 1'b1, restart: 1'b0, exp_sum: 32'h100};
    vecs[2] = '{mode: 3, preset: 1'b1, restart: 1'b0, exp_sum: 32'h100};
    vecs[3] = '{mode: 0, preset: 1'b1, restart: 1'b1, exp_sum: 32'h100};
    vecs[4] = '{mode: 2, preset: 1'b0, restart: 1'b0, exp_sum: 32'h0};
    vecs[5] = '{mode: 2, preset: 1'b0, restart: 1'b0, exp_sum: 32'h0};

    dif.out_ready = 1'b0;
    sif.out_ready = 1'b0;
    load_regs(1'b1);
    s_regs[0] = 32'd0; s_regs[1] = 32'd1; s_regs[2] = 32'd2; s_regs[3] = 32'd4;
    repeat (3) @(negedge clk);
    check("rst_out_valid", dif.out_valid, 0);
    check("rst_out_addr", dif.out_addr, 0);
    check("rst_out_data", dif.out_data, 0);
    check("rst_checksum", checksum, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_hold", hold, 0);
    check("rst_addr", addr, 0);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_dump(vecs[i]);

    // Reset while beat 12 is on the output aborts the dump without a done pulse.
    begin
      int  n;
      bit  saw_done;
      load_regs(1'b1);
      dif.out_ready = 1'b1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 0;
      while (!(dif.out_valid && dif.out_addr == 12) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("reach_beat12", dif.out_valid && dif.out_addr == 12, 1);
      rst = 1'b0;
      @(negedge clk) rst = 1'b1;
      check("abort_out_valid", dif.out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_hold", hold, 0);
      check("abort_checksum", checksum, 0);
      check("abort_addr", addr, 0);
      saw_done = 0;
      repeat (40) begin
        if (done) saw_done = 1;
        @(negedge clk);
      end
      check("abort_no_done", saw_done, 0);
      run_dump(vecs[0]);
    end

    // Four registers across the whole 2-bit address space: no wrap, done at T+6.
    begin
      sif.out_ready = 1'b1;
      @(negedge clk) s_start = 1'b1;
      @(negedge clk) s_start = 1'b0;
      for (int k = 1; k <= 7; k++) begin
        if (k >= 2 && k <= 5) begin
          check("small_valid", sif.out_valid, 1);
          check("small_addr", sif.out_addr, k - 2);
          check("small_data", sif.out_data, s_regs[k - 2]);
        end
        if (k == 5) check("small_early_done", s_done, 0);
        if (k == 6) begin
          check("small_done", s_done, 1);
          check("small_checksum", s_checksum, 32'h7);
          check("small_valid_after", sif.out_valid, 0);
        end
        if (k == 7) check("small_busy_end", s_busy, 0);
        @(negedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
